// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction-fetch controller placed between the program-counter logic and
// a synchronous-read instruction ROM (registered output, one-cycle latency).
// Launches one ROM read per cycle, catches the word one cycle later into a
// single-entry output slot and hands it to decode through valid/ready.
// Under backpressure the same address is re-read so that rom_q stays stable
// and nothing is lost. Redirect restarts fetch at a new address. A word
// whose opcode equals HALT_OPCODE stops fetching until the next redirect.
//
// Ports:
//   clk           rising-edge clock, shared with the ROM
//   rst_n         asynchronous active-low reset
//   rom_addr      ROM address (combinational: redirect / re-read / pc)
//   rom_q         ROM registered read data
//   instr         fetched instruction (slot register)
//   instr_pc      address of instr
//   instr_valid   slot holds a valid instruction
//   instr_ready   decode takes the slot this cycle
//   redirect      single-cycle request to restart fetch at redirect_addr
//   redirect_addr redirect target
//   halted        high while fetching is stopped by a halt word
// ---------------------------------------------------------------------------
module fetch_ctrl #(
   parameter int          DATA_WIDTH  = 32,
   parameter int          ADDR_WIDTH  = 9,
   parameter int          START_ADDR  = 1,
   parameter logic [5:0]  HALT_OPCODE = 6'b010001
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_q,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_addr,
   output logic                  halted
);

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_HALTED = 1'b1;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_START = ADDR_WIDTH'(START_ADDR);

   logic [0:0]            state_r;
   logic [ADDR_WIDTH-1:0] pc_r;
   logic                  launched_r;
   logic [ADDR_WIDTH-1:0] launched_pc_r;
   logic [DATA_WIDTH-1:0] instr_r;
   logic [ADDR_WIDTH-1:0] instr_pc_r;
   logic                  instr_valid_r;

   logic                  accept_s;
   logic                  hold_s;
   logic                  halt_hit_s;

   // Slot can take a new word when empty or being consumed; otherwise a
   // word in flight must be re-read until the slot frees up.
   always_comb begin
      accept_s   = !instr_valid_r || instr_ready;
      hold_s     = launched_r && !accept_s;
      halt_hit_s = (rom_q[DATA_WIDTH-1 -: 6] == HALT_OPCODE);
   end

   // ROM address select: redirect target, re-read of the in-flight word, or pc.
   always_comb begin
      rom_addr = pc_r;
      if (redirect) begin
         rom_addr = redirect_addr;
      end else if (hold_s) begin
         rom_addr = launched_pc_r;
      end else begin
         rom_addr = pc_r;
      end
   end

   // Fetch state, pc, in-flight tracking and the output slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_RUN;
         pc_r          <= ADDR_START;
         launched_r    <= 1'b0;
         launched_pc_r <= {ADDR_WIDTH{1'b0}};
         instr_r       <= {DATA_WIDTH{1'b0}};
         instr_pc_r    <= {ADDR_WIDTH{1'b0}};
         instr_valid_r <= 1'b0;
      end else if (redirect) begin
         // Flush slot and in-flight word; the redirect target is read now.
         instr_valid_r <= 1'b0;
         launched_r    <= 1'b1;
         launched_pc_r <= redirect_addr;
         pc_r          <= redirect_addr + ADDR_ONE;
         state_r       <= ST_RUN;
      end else if (launched_r && accept_s) begin
         instr_r       <= rom_q;
         instr_pc_r    <= launched_pc_r;
         instr_valid_r <= 1'b1;
         if (halt_hit_s) begin
            // The halt word is delivered but nothing after it is launched.
            state_r    <= ST_HALTED;
            launched_r <= 1'b0;
            pc_r       <= launched_pc_r + ADDR_ONE;
         end else if (state_r == ST_RUN) begin
            launched_r    <= 1'b1;
            launched_pc_r <= pc_r;
            pc_r          <= pc_r + ADDR_ONE;
         end else begin
            launched_r <= 1'b0;
         end
      end else if (launched_r) begin
         // Backpressure: everything holds while the same word is re-read.
         launched_r <= launched_r;
      end else if (state_r == ST_RUN) begin
         launched_r    <= 1'b1;
         launched_pc_r <= pc_r;
         pc_r          <= pc_r + ADDR_ONE;
         if (instr_ready && instr_valid_r) begin
            instr_valid_r <= 1'b0;
         end else begin
            instr_valid_r <= instr_valid_r;
         end
      end else begin
         // Halted: no launches, the slot simply drains.
         if (instr_ready && instr_valid_r) begin
            instr_valid_r <= 1'b0;
         end else begin
            instr_valid_r <= instr_valid_r;
         end
      end
   end

   assign instr       = instr_r;
   assign instr_pc    = instr_pc_r;
   assign instr_valid = instr_valid_r;
   assign halted      = (state_r == ST_HALTED);

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Directed bench for fetch_ctrl with a behavioural one-cycle-latency ROM.
// A table of per-cycle records gives the inputs for one clock and the
// expected rom_addr before the edge plus slot/halted state after it.
// A hand-written sequence covers asynchronous reset in mid-stream.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

   logic        clk;
   logic        rst_n;
   logic [8:0]  rom_addr;
   logic [31:0] rom_q;
   logic [31:0] instr;
   logic [8:0]  instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [8:0]  redirect_addr;
   logic        halted;

   logic [31:0] rom_mem [0:511];

   int n_tests;
   int n_fail;

   typedef struct {
      logic       ready;
      logic       redir;
      logic [8:0] raddr;
      logic [8:0] exp_ra;
      logic       exp_v;
      logic [8:0] exp_pc;
      logic       exp_h;
   } vec_t;

   vec_t vecs [0:63];
   int   nv;

   fetch_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rom_addr      (rom_addr),
      .rom_q         (rom_q),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .halted        (halted)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous-read ROM: registered output, one-cycle latency.
   always @(posedge clk) begin
      rom_q <= rom_mem[rom_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic r, input logic rd, input logic [8:0] ra,
                      input logic [8:0] ea, input logic ev, input logic [8:0] ep,
                      input logic eh);
      vecs[nv].ready  = r;
      vecs[nv].redir  = rd;
      vecs[nv].raddr  = ra;
      vecs[nv].exp_ra = ea;
      vecs[nv].exp_v  = ev;
      vecs[nv].exp_pc = ep;
      vecs[nv].exp_h  = eh;
      nv++;
   endtask

   initial begin
      logic [8:0] a;
      n_tests = 0;
      n_fail  = 0;
      nv      = 0;

      for (int i = 0; i < 512; i++) begin
         a = i[8:0];
         rom_mem[i] = {6'b000010, 8'hA5, a, a ^ 9'h1FF};
      end
      rom_mem[67][31:26]  = 6'b010001;
      rom_mem[301][31:26] = 6'b010001;

      // ready redir raddr | rom_addr valid pc halted
      add(1'b1, 1'b0, 9'd0,   9'd1,   1'b0, 9'd0,   1'b0);  // launch 1
      add(1'b1, 1'b0, 9'd0,   9'd2,   1'b1, 9'd1,   1'b0);
      add(1'b1, 1'b0, 9'd0,   9'd3,   1'b1, 9'd2,   1'b0);
      add(1'b1, 1'b0, 9'd0,   9'd4,   1'b1, 9'd3,   1'b0);
      add(1'b1, 1'b0, 9'd0,   9'd5,   1'b1, 9'd4,   1'b0);
      add(1'b1, 1'b0, 9'd0,   9'd6,   1'b1, 9'd5,   1'b0);
      add(1'b0, 1'b0, 9'd0,   9'd6,   1'b1, 9'd5,   1'b0);  // backpressure x3
      add(1'b0, 1'b0, 9'd0,   9'd6,   1'b1, 9'd5,   1'b0);
      add(1'b0, 1'b0, 9'd0,   9'd6,   1'b1, 9'd5,   1'b0);
      add(1'b1, 1'b0, 9'd0,   9'd7,   1'b1, 9'd6,   1'b0);
      add(1'b1, 1'b0, 9'd0,   9'd8,   1'b1, 9'd7,   1'b0);
      add(1'b1, 1'b1, 9'd47,  9'd47,  1'b0, 9'd0,   1'b0);  // redirect 47
      add(1'b1, 1'b0, 9'd0,   9'd48,  1'b1, 9'd47,  1'b0);
      add(1'b1, 1'b0, 9'd0,   9'd49,  1'b1, 9'd48,  1'b0);
      add(1'b1, 1'b1, 9'd65,  9'd65,  1'b0, 9'd0,   1'b0);  // toward halt at 67
      add(1'b1, 1'b0, 9'd0,   9'd66,  1'b1, 9'd65,  1'b0);
      add(1'b1, 1'b0, 9'd0,   9'd67,  1'b1, 9'd66,  1'b0);
      add(1'b1, 1'b0, 9'd0,   9'd68,  1'b1, 9'd67,  1'b1);  // halt word delivered
      add(1'b1, 1'b0, 9'd0,   9'd68,  1'b0, 9'd0,   1'b1);
      add(1'b1, 1'b0, 9'd0,   9'd68,  1'b0, 9'd0,   1'b1);
      add(1'b1, 1'b0, 9'd0,   9'd68,  1'b0, 9'd0,   1'b1);
      add(1'b1, 1'b1, 9'd1,   9'd1,   1'b0, 9'd0,   1'b0);  // leave halt
      add(1'b1, 1'b0, 9'd0,   9'd2,   1'b1, 9'd1,   1'b0);
      add(1'b1, 1'b0, 9'd0,   9'd3,   1'b1, 9'd2,   1'b0);
      add(1'b1, 1'b1, 9'd511, 9'd511, 1'b0, 9'd0,   1'b0);  // wrap
      add(1'b1, 1'b0, 9'd0,   9'd0,   1'b1, 9'd511, 1'b0);
      add(1'b1, 1'b0, 9'd0,   9'd1,   1'b1, 9'd0,   1'b0);
      add(1'b0, 1'b1, 9'd200, 9'd200, 1'b0, 9'd0,   1'b0);  // redirect under backpressure
      add(1'b0, 1'b0, 9'd0,   9'd201, 1'b1, 9'd200, 1'b0);
      add(1'b0, 1'b0, 9'd0,   9'd201, 1'b1, 9'd200, 1'b0);
      add(1'b1, 1'b0, 9'd0,   9'd202, 1'b1, 9'd201, 1'b0);
      add(1'b1, 1'b1, 9'd300, 9'd300, 1'b0, 9'd0,   1'b0);  // halt word at 301 in flight
      add(1'b1, 1'b0, 9'd0,   9'd301, 1'b1, 9'd300, 1'b0);
      add(1'b1, 1'b1, 9'd10,  9'd10,  1'b0, 9'd0,   1'b0);  // redirect beats halt load
      add(1'b1, 1'b0, 9'd0,   9'd11,  1'b1, 9'd10,  1'b0);
      add(1'b1, 1'b0, 9'd0,   9'd12,  1'b1, 9'd11,  1'b0);

      // Reset state
      rst_n         = 1'b0;
      instr_ready   = 1'b1;
      redirect      = 1'b0;
      redirect_addr = 9'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_valid",    {31'd0, instr_valid}, 32'd0);
      chk("rst_pc",       {23'd0, instr_pc},    32'd0);
      chk("rst_instr",    instr,                32'd0);
      chk("rst_halted",   {31'd0, halted},      32'd0);
      chk("rst_rom_addr", {23'd0, rom_addr},    32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Table: each record starts at a negedge and covers one rising edge.
      for (int v = 0; v < nv; v++) begin
         instr_ready   = vecs[v].ready;
         redirect      = vecs[v].redir;
         redirect_addr = vecs[v].raddr;
         #1;
         chk($sformatf("v%0d_rom_addr", v), {23'd0, rom_addr}, {23'd0, vecs[v].exp_ra});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_valid", v),  {31'd0, instr_valid}, {31'd0, vecs[v].exp_v});
         chk($sformatf("v%0d_halted", v), {31'd0, halted},      {31'd0, vecs[v].exp_h});
         if (vecs[v].exp_v) begin
            chk($sformatf("v%0d_pc", v),    {23'd0, instr_pc}, {23'd0, vecs[v].exp_pc});
            chk($sformatf("v%0d_instr", v), instr,             rom_mem[vecs[v].exp_pc]);
         end
         @(negedge clk);
      end

      // Asynchronous reset mid-stream with decode stalled.
      instr_ready = 1'b0;
      redirect    = 1'b0;
      @(posedge clk);
      #1;
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_pc",    {23'd0, instr_pc},    32'd11);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid",    {31'd0, instr_valid}, 32'd0);
      chk("mid_rst_pc",       {23'd0, instr_pc},    32'd0);
      chk("mid_rst_instr",    instr,                32'd0);
      chk("mid_rst_halted",   {31'd0, halted},      32'd0);
      chk("mid_rst_rom_addr", {23'd0, rom_addr},    32'd1);
      @(negedge clk);
      @(negedge clk);
      instr_ready = 1'b1;
      rst_n       = 1'b1;
      @(posedge clk);
      #1;
      chk("restart_e1_valid", {31'd0, instr_valid}, 32'd0);
      @(posedge clk);
      #1;
      chk("restart_e2_valid", {31'd0, instr_valid}, 32'd1);
      chk("restart_e2_pc",    {23'd0, instr_pc},    32'd1);
      chk("restart_e2_instr", instr,                rom_mem[1]);
      @(posedge clk);
      #1;
      chk("restart_e3_pc",    {23'd0, instr_pc},    32'd2);
      chk("restart_e3_instr", instr,                rom_mem[2]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
